// File: rtl/enemy_controller_if.sv
// Signal bundle between the raster/game logic and one enemy_controller instance.
// master drives raster position, scroll and stomp; slave returns sprite placement.
interface enemy_controller_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [11:0] offset_background;
  logic        collision_info;
  logic [12:0] x_out;
  logic [9:0]  y_out;
  logic [1:0]  image_index;
  logic        no_enemy;
  logic [1:0]  state_out;

  modport master (
    output hcount_in, vcount_in, offset_background, collision_info,
    input  x_out, y_out, image_index, no_enemy, state_out
  );

  modport slave (
    input  hcount_in, vcount_in, offset_background, collision_info,
    output x_out, y_out, image_index, no_enemy, state_out
  );
endinterface

// File: rtl/enemy_controller.sv
// Per-enemy behaviour engine: spawn on scroll-in, patrol between bounds, squish on stomp, vanish.
// Everything advances once per video frame on the blanking-line tick; collision acts immediately.
module enemy_controller #(
  parameter logic [12:0] SPAWN_X       = 13'd700,
  parameter logic [9:0]  GROUND_Y      = 10'd208,
  parameter logic [12:0] LEFT_BOUND    = 13'd600,
  parameter logic [12:0] RIGHT_BOUND   = 13'd800,
  parameter logic [3:0]  SPEED         = 4'd1,
  parameter int unsigned ANIM_FRAMES   = 8,
  parameter int unsigned SQUISH_FRAMES = 30,
  parameter int unsigned SCREEN_W      = 576
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  enemy_controller_if.slave bus
);

  localparam int unsigned ANIM_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int unsigned SQUISH_W = (SQUISH_FRAMES > 1) ? $clog2(SQUISH_FRAMES) : 1;
  localparam logic [ANIM_W-1:0]   ANIM_LAST   = ANIM_W'(ANIM_FRAMES - 1);
  localparam logic [SQUISH_W-1:0] SQUISH_LAST = SQUISH_W'(SQUISH_FRAMES - 1);
  localparam logic [13:0] LEFT_TURN  = 14'(LEFT_BOUND) + 14'(SPEED);
  localparam logic [13:0] RIGHT_LIM  = 14'(RIGHT_BOUND);
  localparam logic [12:0] SCREEN_W13 = 13'(SCREEN_W);
  localparam logic        DIR_LEFT   = 1'b0;
  localparam logic        DIR_RIGHT  = 1'b1;
  localparam logic [1:0]  IMG_WALK0  = 2'd0;
  localparam logic [1:0]  IMG_WALK1  = 2'd1;
  localparam logic [1:0]  IMG_SQUISH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WALK   = 2'd1,
    S_SQUISH = 2'd2,
    S_DEAD   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [12:0]           x_q, x_d;
  logic [1:0]            img_q, img_d;
  logic                  no_enemy_q, no_enemy_d;
  logic                  dir_q, dir_d;
  logic [ANIM_W-1:0]     anim_q, anim_d;
  logic [SQUISH_W-1:0]   squish_q, squish_d;

  logic                  tick_c;
  logic                  visible_c;
  logic [13:0]           right_sum_c;

  // Frame tick: first pixel of the first line after the 240-line active area.
  assign tick_c      = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd240);
  assign visible_c   = (13'({1'b0, bus.offset_background}) + SCREEN_W13) > SPAWN_X;
  assign right_sum_c = {1'b0, x_q} + 14'(SPEED);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    img_d      = img_q;
    no_enemy_d = no_enemy_q;
    dir_d      = dir_q;
    anim_d     = anim_q;
    squish_d   = squish_q;

    unique case (state_q)
      S_IDLE: begin
        x_d        = SPAWN_X;
        img_d      = IMG_WALK0;
        no_enemy_d = 1'b1;
        dir_d      = DIR_LEFT;
        anim_d     = '0;
        squish_d   = '0;
        if (tick_c && visible_c) begin
          state_d    = S_WALK;
          no_enemy_d = 1'b0;
        end
      end

      S_WALK: begin
        if (bus.collision_info) begin
          state_d  = S_SQUISH;
          img_d    = IMG_SQUISH;
          squish_d = '0;
        end else if (tick_c) begin
          // Clamp at the bounds so the enemy never overshoots or wraps.
          if (dir_q == DIR_LEFT) begin
            if ({1'b0, x_q} <= LEFT_TURN) begin
              x_d   = LEFT_BOUND;
              dir_d = DIR_RIGHT;
            end else begin
              x_d = x_q - 13'(SPEED);
            end
          end else begin
            if (right_sum_c >= RIGHT_LIM) begin
              x_d   = RIGHT_BOUND;
              dir_d = DIR_LEFT;
            end else begin
              x_d = right_sum_c[12:0];
            end
          end
          if (anim_q == ANIM_LAST) begin
            anim_d = '0;
            img_d  = (img_q == IMG_WALK0) ? IMG_WALK1 : IMG_WALK0;
          end else begin
            anim_d = anim_q + ANIM_W'(1);
          end
        end
      end

      S_SQUISH: begin
        if (tick_c) begin
          if (squish_q == SQUISH_LAST) begin
            state_d    = S_DEAD;
            no_enemy_d = 1'b1;
            img_d      = IMG_WALK0;
          end else begin
            squish_d = squish_q + SQUISH_W'(1);
          end
        end
      end

      S_DEAD: begin
        no_enemy_d = 1'b1;
        img_d      = IMG_WALK0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      x_q        <= SPAWN_X;
      img_q      <= IMG_WALK0;
      no_enemy_q <= 1'b1;
      dir_q      <= DIR_LEFT;
      anim_q     <= '0;
      squish_q   <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      img_q      <= img_d;
      no_enemy_q <= no_enemy_d;
      dir_q      <= dir_d;
      anim_q     <= anim_d;
      squish_q   <= squish_d;
    end
  end

  assign bus.x_out       = x_q;
  assign bus.y_out       = GROUND_Y;
  assign bus.image_index = img_q;
  assign bus.no_enemy    = no_enemy_q;
  assign bus.state_out   = state_q;

endmodule
